// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and default parameters for mem_port_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, one access in flight
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  state_t state, state_nxt;
  owner_t owner;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic we_q, arb, pick_if, capture, issue, resp;
  logic [3:0] starve_cnt;
  logic [2:0] lat_cnt;
  assign arb     = if_req | dm_req;
  assign pick_if = if_req & (~dm_req | (starve_cnt == 4'(STARVE_MAX)));
  // with MEM_LAT=1 there is no WAIT cycle, so data is taken as ISSUE ends
  assign capture = (state == S_ISSUE && MEM_LAT == 1) || (state == S_WAIT && lat_cnt == 3'd1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == S_IDLE  ? (arb ? S_ISSUE : S_IDLE) :
                state == S_ISSUE ? (MEM_LAT == 1 ? S_RESP : S_WAIT) :
                state == S_WAIT  ? (lat_cnt == 3'd1 ? S_RESP : S_WAIT) : S_IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      owner      <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if (state == S_IDLE && arb) begin
        owner      <= pick_if ? OWN_IF : OWN_DM;
        addr_q     <= pick_if ? if_addr : dm_addr;
        we_q       <= ~pick_if & dm_we;
        wdata_q    <= pick_if ? '0 : dm_wdata;
        starve_cnt <= pick_if ? 4'd0 : (if_req && starve_cnt != 4'(STARVE_MAX)) ? starve_cnt + 4'd1 : starve_cnt;
      end
      lat_cnt <= state == S_ISSUE ? 3'(MEM_LAT - 1) : state == S_WAIT ? lat_cnt - 3'd1 : 3'd0;
      if (capture && owner == OWN_IF) if_rdata <= mem_rdata;
      if (capture && owner == OWN_DM && !we_q) dm_rdata <= mem_rdata;
    end
  always_comb begin
    issue     = state == S_ISSUE;
    resp      = state == S_RESP;
    mem_en    = issue;
    mem_we    = issue & we_q;
    mem_addr  = issue ? addr_q : '0;
    mem_wdata = issue ? wdata_q : '0;
    if_gnt    = issue & (owner == OWN_IF);
    dm_gnt    = issue & (owner == OWN_DM);
    if_rvalid = resp & (owner == OWN_IF);
    dm_rvalid = resp & (owner == OWN_DM);
    busy      = state != S_IDLE;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter against a synchronous memory model
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst;
  logic if_req, if_gnt, if_rvalid, dm_req, dm_we, dm_gnt, dm_rvalid;
  logic mem_en, mem_we, busy;
  logic [9:0] if_addr, dm_addr, mem_addr, ra, pre_a;
  logic [31:0] if_rdata, dm_rdata, dm_wdata, mem_wdata, mem_rdata, pre_d;
  logic pre_we;
  logic [31:0] mem [0:1023];
  int n_vec = 0, n_err = 0, who;
  always #5 clk = ~clk;
  mem_port_arbiter #(.DATA_W(32), .ADDR_W(10), .MEM_LAT(2), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );
  // registered-address RAM: data appears the cycle after mem_en
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en) ra <= mem_addr;
  end
  assign mem_rdata = mem[ra];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    pre_we = 0; pre_a = 0; pre_d = 0; ra = 0;
    tick();
    pre_we = 1; pre_a = 10'd5; pre_d = 32'h1234;
    tick();
    pre_a = 10'd7; pre_d = 32'hAA;
    tick();
    pre_we = 0;
    chk("rst_ctl", {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy}, 0);
    chk("rst_bus", {mem_addr, mem_wdata}, 0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 0);
    rst = 1'b0;
    // single fetch, MEM_LAT=2
    if_req = 1; if_addr = 10'd5;
    tick();
    chk("f_gnt", {if_gnt, dm_gnt, mem_en, mem_we, busy}, 5'b10101);
    chk("f_addr", mem_addr, 10'd5);
    if_req = 0;
    tick();
    chk("f_wait", {if_gnt, if_rvalid, mem_en}, 0);
    tick();
    chk("f_rvalid", {if_rvalid, dm_rvalid}, 2'b10);
    chk("f_rdata", if_rdata, 32'h1234);
    tick();
    chk("f_idle", {if_rvalid, busy}, 0);
    chk("f_hold", if_rdata, 32'h1234);
    // simultaneous requests: dm first, fetch four cycles later
    dm_req = 1; dm_we = 0; dm_addr = 10'd7; if_req = 1; if_addr = 10'd2;
    tick();
    chk("b_dm_first", {dm_gnt, if_gnt}, 2'b10);
    chk("b_addr", mem_addr, 10'd7);
    dm_req = 0;
    tick();
    tick();
    chk("b_dm_rvalid", {dm_rvalid, if_rvalid}, 2'b10);
    chk("b_dm_rdata", dm_rdata, 32'hAA);
    tick();
    chk("b_gap", {if_gnt, dm_gnt, busy}, 0);
    tick();
    chk("b_if_gnt", {if_gnt, dm_gnt}, 2'b10);
    chk("b_if_addr", mem_addr, 10'd2);
    if_req = 0;
    tick(); tick(); tick();
    chk("b_idle", busy, 0);
    // starvation: three dm grants then a forced fetch
    dm_req = 1; dm_we = 0; dm_addr = 10'd7; if_req = 1; if_addr = 10'd2;
    for (int g = 0; g < 4; g++) begin
      who = -1;
      for (int i = 0; i < 8 && who < 0; i++) begin
        tick();
        if (dm_gnt) who = 1;
        else if (if_gnt) who = 0;
      end
      chk($sformatf("starve_g%0d", g), who, g == 3 ? 0 : 1);
    end
    chk("starve_clr", dut.starve_cnt, 0);
    if_req = 0; dm_req = 0;
    tick(); tick(); tick();
    chk("s_idle", busy, 0);
    // store then load back
    dm_req = 1; dm_we = 1; dm_addr = 10'd9; dm_wdata = 32'hDEADBEEF;
    tick();
    chk("st_gnt", {dm_gnt, mem_en, mem_we}, 3'b111);
    chk("st_bus", {mem_addr, mem_wdata}, {10'd9, 32'hDEADBEEF});
    dm_req = 0;
    tick();
    chk("st_we_once", {mem_we, mem_en}, 0);
    tick();
    chk("st_rvalid", dm_rvalid, 1);
    chk("st_rdata_hold", dm_rdata, 32'hAA);
    tick();
    dm_req = 1; dm_we = 0;
    tick();
    chk("ld_gnt", {dm_gnt, mem_we}, 2'b10);
    dm_req = 0;
    tick(); tick();
    chk("ld_rvalid", dm_rvalid, 1);
    chk("ld_rdata", dm_rdata, 32'hDEADBEEF);
    tick();
    // reset during WAIT abandons the access
    if_req = 1; if_addr = 10'd5;
    tick();
    chk("r_gnt", if_gnt, 1);
    if_req = 0;
    tick();
    rst = 1;
    #1;
    chk("r_async", {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy}, 0);
    chk("r_rdata", {if_rdata, dm_rdata}, 0);
    if_req = 1;
    tick();
    chk("r_held", {if_gnt, if_rvalid, busy}, 0);
    rst = 0;
    tick();
    chk("r_first_edge", {if_gnt, mem_en}, 2'b11);
    if_req = 0;
    tick(); tick();
    chk("r_rvalid", if_rvalid, 1);
    chk("r_rdata2", if_rdata, 32'h1234);
    tick();
    chk("r_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
